// File: rtl/reg_scan_viewer.sv
// reg_scan_viewer: walks r0..r(NUM_REGS-1) of the processor register file and
// presents one register at a time (index + value) to the seven-segment path.
// Advances on a dwell timer (auto_en=1) or on a debounced push-button event.
// Optional build macro REG_SCAN_SNAPSHOT_EN: value_out is taken from a shadow
// bank captured on the wrap to index 0 (and on the first LOAD after reset),
// so each full scan shows one coherent snapshot of the register file.
module reg_scan_viewer #(
  parameter int WIDTH           = 16,
  parameter int NUM_REGS        = 16,
  parameter int DWELL_CYCLES    = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*NUM_REGS-1:0] regs_flat,
  input  logic                      step_btn,
  input  logic                      auto_en,
  output logic [3:0]                sel_out,
  output logic [WIDTH-1:0]          value_out,
  output logic                      valid,
  output logic                      wrap_pulse
);

  localparam int SEL_W   = 4;
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {S_LOAD, S_SHOW, S_ADV} state_t;

  // Unpack the flattened register bus into an indexable array.
  logic [WIDTH-1:0] reg_arr [NUM_REGS];
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
    assign reg_arr[gi] = regs_flat[gi*WIDTH +: WIDTH];
  end

  // ---------------- button path ----------------
  logic            sync1_q, sync2_q;
  logic            db_level_q, db_prev_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            step_evt;

  // Two-flop synchroniser, then a level debouncer that only accepts a new
  // level once the synchronised input has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q   <= step_btn;
      sync2_q   <= sync1_q;
      db_prev_q <= db_level_q;
      if (sync2_q == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level_q <= sync2_q;
        db_cnt_q   <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  // One pulse per debounced press; holding the button yields a single event.
  assign step_evt = db_level_q & ~db_prev_q;

  // ---------------- scan FSM ----------------
  state_t             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [WIDTH-1:0]   value_q;
  logic               valid_q;
  logic               wrap_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               sel_last;
  logic               dwell_done;
  logic [WIDTH-1:0]   src_value;

  assign sel_last   = (sel_q == SEL_W'(NUM_REGS - 1));
  assign dwell_done = auto_en && (dwell_q == DWELL_W'(DWELL_CYCLES - 1));

`ifdef REG_SCAN_SNAPSHOT_EN
  logic [WIDTH-1:0] shadow_q [NUM_REGS];
  logic             snap_init_q;
  logic             snap_capture;

  // Capture the whole bank on the wrap to index 0 and on the first LOAD.
  assign snap_capture = ((state_q == S_ADV) && sel_last) ||
                        ((state_q == S_LOAD) && snap_init_q);

  // Shadow bank: holds the register file image shown during one scan.
  always_ff @(posedge clk) begin
    if (snap_capture) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= reg_arr[i];
      end
    end
  end

  // Marks that no snapshot exists yet since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_init_q <= 1'b1;
    end else if (state_q == S_LOAD) begin
      snap_init_q <= 1'b0;
    end
  end

  // On the very first LOAD the bank is being filled, so read live data once.
  assign src_value = snap_init_q ? reg_arr[sel_q] : shadow_q[sel_q];
`else
  assign src_value = reg_arr[sel_q];
`endif

  // LOAD -> SHOW -> ADV sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      sel_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          value_q <= src_value;
          valid_q <= 1'b0;
          wrap_q  <= 1'b0;
          state_q <= S_SHOW;
        end
        S_SHOW: begin
          value_q <= src_value;
          valid_q <= 1'b1;
          wrap_q  <= 1'b0;
          dwell_q <= auto_en ? dwell_q + DWELL_W'(1) : '0;
          // A step and a dwell expiry in the same cycle give one advance.
          if (step_evt || dwell_done) begin
            state_q <= S_ADV;
          end
        end
        S_ADV: begin
          sel_q   <= sel_last ? '0 : sel_q + SEL_W'(1);
          wrap_q  <= sel_last;
          dwell_q <= '0;
          valid_q <= 1'b0;
          state_q <= S_LOAD;
        end
        default: begin
          state_q <= S_LOAD;
          valid_q <= 1'b0;
          wrap_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_out    = sel_q;
  assign value_out  = value_q;
  assign valid      = valid_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_reg_scan_viewer.sv
// Directed bench for reg_scan_viewer with DWELL_CYCLES=4, DEBOUNCE_CYCLES=3.
// k counts clock edges since reset was released (k=0: state right after reset).
module tb_reg_scan_viewer;

  localparam int WIDTH = 16;
  localparam int NREG  = 16;

  logic                   clk;
  logic                   reset;
  logic [WIDTH*NREG-1:0]  regs_flat;
  logic                   step_btn;
  logic                   auto_en;
  logic [3:0]             sel_out;
  logic [WIDTH-1:0]       value_out;
  logic                   valid;
  logic                   wrap_pulse;

  int checks = 0;
  int errors = 0;
  int k = 0;

  reg_scan_viewer #(
    .WIDTH(WIDTH), .NUM_REGS(NREG), .DWELL_CYCLES(4), .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .regs_flat(regs_flat), .step_btn(step_btn),
    .auto_en(auto_en), .sel_out(sel_out), .value_out(value_out),
    .valid(valid), .wrap_pulse(wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic        auto_in;
    logic [3:0]  sel;
    logic [15:0] val;
    logic        vld;
    logic        wrp;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic tick_to(input int target);
    while (k < target) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic set_regs_default();
    for (int i = 0; i < NREG; i++) regs_flat[i*WIDTH +: WIDTH] = 16'(i * 16'h0101);
  endtask

  task automatic reset_dut(input logic a);
    reset    = 1'b1;
    step_btn = 1'b0;
    auto_en  = a;
    set_regs_default();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    k = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int changes;
    logic [3:0] prev_sel;
    logic [15:0] exp_r3;

    //       k   auto sel    value     vld  wrp
    tbl[0]  = '{0,  1'b1, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b1, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{2,  1'b1, 4'd0,  16'h0000, 1'b1, 1'b0};
    tbl[3]  = '{5,  1'b1, 4'd0,  16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{6,  1'b1, 4'd1,  16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{7,  1'b1, 4'd1,  16'h0101, 1'b0, 1'b0};
    tbl[6]  = '{8,  1'b1, 4'd1,  16'h0101, 1'b1, 1'b0};
    tbl[7]  = '{12, 1'b1, 4'd2,  16'h0101, 1'b0, 1'b0};
    tbl[8]  = '{14, 1'b1, 4'd2,  16'h0202, 1'b1, 1'b0};
    tbl[9]  = '{95, 1'b1, 4'd15, 16'h0F0F, 1'b1, 1'b0};
    tbl[10] = '{96, 1'b1, 4'd0,  16'h0F0F, 1'b0, 1'b1};
    tbl[11] = '{97, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[12] = '{98, 1'b1, 4'd0,  16'h0000, 1'b1, 1'b0};

    // Auto scan: reset state, latency, period, wrap pulse.
    reset_dut(1'b1);
    for (int i = 0; i < 13; i++) begin
      tick_to(tbl[i].k);
      auto_en = tbl[i].auto_in;
      check("vec_sel",   32'(sel_out),    32'(tbl[i].sel));
      check("vec_value", 32'(value_out),  32'(tbl[i].val));
      check("vec_valid", 32'(valid),      32'(tbl[i].vld));
      check("vec_wrap",  32'(wrap_pulse), 32'(tbl[i].wrp));
      $display("vec %0d k=%0d sel=%0d value=%h valid=%b wrap=%b",
               i, k, sel_out, value_out, valid, wrap_pulse);
    end

    // auto_en dropped at dwell=2 for 20 cycles, then re-enabled.
    reset_dut(1'b1);
    tick_to(3);
    auto_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_sel", 32'(sel_out), 32'd0);
    end
    auto_en = 1'b1;
    tick_to(27);
    check("reen_before", 32'(sel_out), 32'd0);
    tick();
    check("reen_adv", 32'(sel_out), 32'd1);
    $display("toggle: sel=%0d at k=%0d", sel_out, k);

    // Step event aligned with dwell expiry of r1 (both hit at edge 11).
    reset_dut(1'b1);
    tick_to(5);
    step_btn = 1'b1;
    tick_to(12);
    check("coinc_adv", 32'(sel_out), 32'd2);
    tick_to(17);
    check("coinc_hold", 32'(sel_out), 32'd2);
    tick();
    check("coinc_next", 32'(sel_out), 32'd3);
    step_btn = 1'b0;
    $display("coincide: sel=%0d at k=%0d", sel_out, k);

    // Bouncing button then held high, manual mode.
    reset_dut(1'b0);
    tick_to(2);
    for (int i = 0; i < 4; i++) begin
      step_btn = (i % 2 == 0);
      tick();
    end
    check("bounce_noadv", 32'(sel_out), 32'd0);
    step_btn = 1'b1;
    changes = 0;
    prev_sel = sel_out;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sel_out != prev_sel) changes++;
      prev_sel = sel_out;
    end
    check("db_changes", 32'(changes), 32'd1);
    check("db_sel", 32'(sel_out), 32'd1);
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("db_release", 32'(sel_out), 32'd1);
    $display("debounce: changes=%0d sel=%0d", changes, sel_out);

    // Reset while showing r9.
    reset_dut(1'b1);
    tick_to(56);
    check("pre_rst_sel", 32'(sel_out), 32'd9);
    check("pre_rst_valid", 32'(valid), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_sel", 32'(sel_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_wrap", 32'(wrap_pulse), 32'd0);
    check("rst_value", 32'(value_out), 32'd0);
    $display("midreset: sel=%0d valid=%b value=%h", sel_out, valid, value_out);

    // r3 modified while r1 is shown; snapshot build hides it until the wrap.
    reset_dut(1'b1);
    tick_to(8);
    regs_flat[3*WIDTH +: WIDTH] = 16'hBEEF;
`ifdef REG_SCAN_SNAPSHOT_EN
    exp_r3 = 16'h0303;
`else
    exp_r3 = 16'hBEEF;
`endif
    tick_to(20);
    check("r3_sel", 32'(sel_out), 32'd3);
    check("r3_first", 32'(value_out), 32'(exp_r3));
    regs_flat[3*WIDTH +: WIDTH] = 16'h1234;
`ifdef REG_SCAN_SNAPSHOT_EN
    exp_r3 = 16'h0303;
`else
    exp_r3 = 16'h1234;
`endif
    tick();
    check("r3_live", 32'(value_out), 32'(exp_r3));
    check("r3_live_valid", 32'(valid), 32'd1);
    regs_flat[3*WIDTH +: WIDTH] = 16'hBEEF;
    tick_to(116);
    check("r3_second_sel", 32'(sel_out), 32'd3);
    check("r3_second", 32'(value_out), 32'h0000BEEF);
    $display("snapshot: second pass r3=%h", value_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scan_viewer.md
Name: reg_scan_viewer

Overview:
- Read-side companion to the processor register file: walks r0..r15 in order and presents one register at a time to the seven-segment display path (sevSeg_16b).
- Advances automatically on a dwell timer, or manually on a debounced push-button.
- Sits between the processor's register outputs and the display driver on the FPGA board top level.

Parameters:
- WIDTH, 16, register width in bits
- NUM_REGS, 16, registers scanned; index width is 4 bits
- DWELL_CYCLES, 50000000, clock cycles each register is shown in auto mode (>=2)
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised button must be stable before it is accepted (>=2)

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- regs_flat  in  WIDTH*NUM_REGS  flattened register values; r0 = bits [15:0], rN = bits [16N+15:16N]
- step_btn  in  1  raw asynchronous push-button, active-high
- auto_en  in  1  1 = timed auto-advance; 0 = manual step only
- sel_out  out  4  index of the register currently shown
- value_out  out  WIDTH  value of the selected register, to sevSeg_16b .value
- valid  out  1  high while value_out is stable for sel_out
- wrap_pulse  out  1  one-cycle pulse when the index wraps 15 -> 0

Behaviour:
- Reset (clk edge with reset=1):
  - state=LOAD, sel_out=0, value_out=0, valid=0, wrap_pulse=0.
  - Dwell counter=0. Debounce counter, synchroniser and debounced level all cleared to 0.
  - Reset mid-scan discards any pending step event.
- Button path:
  - 2-flop synchroniser feeds the debouncer.
  - The debounced level takes a new value only after the synchronised input has held that value for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
  - step_evt is a 1-cycle pulse on the debounced 0->1 edge. Holding the button gives exactly one event.
- FSM states:
  - LOAD: value_out <= regs_flat[sel_out]; valid <= 0; next state SHOW.
  - SHOW:
    - valid=1; value_out refreshed every cycle from regs_flat[sel_out], so registered, 1-cycle latency.
    - Dwell counter increments while auto_en=1 and is held at 0 while auto_en=0.
    - Exit to ADV when step_evt=1, or when auto_en=1 and dwell==DWELL_CYCLES-1.
    - If both conditions occur in the same cycle, there is a single advance (no double step).
  - ADV:
    - sel_out <= sel_out+1 modulo 16; dwell <= 0; valid <= 0; next state LOAD.
    - wrap_pulse <= 1 when sel_out was 15, registered together with sel_out, so it is high during the first LOAD cycle showing index 0; otherwise 0.
- Timing:
  - First valid value: 2 cycles after reset deasserts (LOAD, then SHOW with value_out=r0, valid=1).
  - Auto period per register: DWELL_CYCLES (SHOW) + 1 (ADV) + 1 (LOAD) = DWELL_CYCLES+2 cycles.
- step_evt arriving during ADV or LOAD is dropped; one advance per SHOW visit.
- auto_en toggled 1->0 mid-dwell: counter clears and the display stays until a step. Toggled 0->1: a full DWELL_CYCLES dwell starts.
- regs_flat changing during SHOW is reflected on value_out the next cycle; valid stays high.

Optional Feature:
- Macro: REG_SCAN_SNAPSHOT_EN
- Defined:
  - A shadow bank of NUM_REGS x WIDTH registers captures all of regs_flat in the ADV cycle that wraps 15->0, and on the first LOAD after reset.
  - value_out is sourced from the shadow bank, so one full scan shows a coherent snapshot.
  - Live changes are invisible until the next wrap.
- Not defined: no shadow bank; value_out tracks regs_flat live as described above.

Test Plan:
- DWELL_CYCLES=4, auto_en=1, rN=N*0x0101 -> reset release cycle 2 shows sel_out=0, value_out=0x0000, valid=1; sel_out=1, value_out=0x0101 from cycle 8; period 6 cycles; after r15=0x0F0F, wrap_pulse is high exactly one cycle with sel_out=0.
- auto_en=0, DEBOUNCE_CYCLES=3, step_btn bouncing 1-0-1-0 at 1-cycle spacing then held high 10 cycles -> exactly one advance (sel_out 0->1); no further advance while held.
- auto_en=1 with a step_evt on the same cycle the dwell expires -> sel_out increments by exactly 1.
- auto_en=1, toggled to 0 at dwell=2 for 20 cycles, then back to 1 -> sel_out unchanged while low; advance occurs DWELL_CYCLES+1 cycles after re-enable.
- reset asserted for 1 cycle while sel_out=9 in SHOW -> next cycle state=LOAD, sel_out=0, valid=0, wrap_pulse=0, value_out=0.
- With REG_SCAN_SNAPSHOT_EN defined: r3 changed 0x0303 -> 0xBEEF while sel_out=1 -> sel_out=3 still shows 0x0303; after the next wrap, sel_out=3 shows 0xBEEF. Without the macro, 0xBEEF appears on the first pass.
